mem_port_scheduler: RTL and testbench
=====================================

# mem_port_scheduler

- Shares the single mem_ctrl transaction port among N_SRC requesters: CPU fetch, CPU data, FPU MMIO and FPU DMA.
- Selects one requester per transaction and forwards its op, address and write data downstream.
- Routes tx_done, rd_valid and read data back only to the granted requester.
- Source 0 (instruction fetch) has fixed top priority; the other sources rotate round-robin. An optional aging mechanism keeps fetch from starving the others.

## Interface

- N_SRC, 4, number of requesters (2–8); index 0 is the priority source.
- ADDR_WIDTH, 32, raw CPU-space address width.
- DATA_WIDTH, 512, cache-line data bus width.
- STARVE_LIMIT, 64, cycles a non-zero source may wait before it overrides source 0 (used only with aging compiled in).

Ports (signal, direction, width, meaning):

- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous and active-high.
- op_src  in  N_SRC×2  per-source op: 00 NOP, 01 READ, 10 WRITE, 11 treated as NOP.
- addr_src  in  N_SRC×ADDR_WIDTH  per-source address.
- wdata_src  in  N_SRC×DATA_WIDTH  per-source write data.
- rdata_src  out  N_SRC×DATA_WIDTH  read data; valid only in the granted slot, 0 elsewhere.
- tx_done_src  out  N_SRC  per-source transaction complete.
- rd_valid_src  out  N_SRC  per-source read data valid.
- op  out  2  op to mem_ctrl.
- raw_address  out  ADDR_WIDTH  address to mem_ctrl.
- common_data_bus_read_in  out  DATA_WIDTH  write data to mem_ctrl.
- common_data_bus_write_out  in  DATA_WIDTH  read data from mem_ctrl.
- tx_done  in  1  mem_ctrl transaction complete.
- rd_valid  in  1  mem_ctrl read data valid.
- grant_id  out  $clog2(N_SRC)  index of the current or last granted source.
- busy  out  1  high in GRANT, WAIT and RELEASE.

## Operation

FSM states:

- IDLE
  - Sample all op_src.
  - If any op is 01 or 10, pick a winner, latch its op, address and wdata into output registers, and go to GRANT.
- GRANT
  - op, raw_address and common_data_bus_read_in are driven from the latches.
  - Go to WAIT.
- WAIT
  - Hold downstream outputs stable.
  - On tx_done, go to RELEASE.
- RELEASE
  - Drive op = 00 for exactly one cycle, then go to IDLE.
  - mem_ctrl therefore sees an op edge between transactions.

Arbitration (evaluated in IDLE only):

- Source 0 wins whenever it requests and no source is starved.
- Otherwise, the first requesting source at or after rr_ptr (range 1..N_SRC-1, wrapping) wins.
- rr_ptr advances to winner+1 (wrapping from N_SRC-1 back to 1) only when a non-zero source wins. It is unchanged when source 0 wins.

Routing:

- tx_done_src[g], rd_valid_src[g] and rdata_src[g] are combinational copies of tx_done, rd_valid and common_data_bus_write_out, where g = grant_id.
- They are passed only while in GRANT or WAIT. Other slots are 0.
- tx_done and rd_valid arriving outside GRANT/WAIT are ignored.

Requester rules:

- Hold op, address and data stable from assertion until the tx_done_src pulse.
- Drop or change op the cycle after tx_done_src.
- Ops are not sampled during RELEASE, so a requester may re-request back-to-back without being double-granted.

Reset:

- Synchronous. State goes to IDLE, rr_ptr = 1, grant_id = 0.
- All outputs and aging counters are cleared.
- A reset in the middle of a transaction abandons it: op = 00 from the cycle after rst is sampled, and no tx_done_src is issued.

## Timing

- Request present in IDLE at cycle N → op and address valid downstream at N+1; grant_id updated at N+1.
- tx_done at cycle M → tx_done_src[g] high in the same cycle M. op = 00 at M+1 (RELEASE); IDLE at M+2; next downstream op no earlier than M+3.
- tx_done in the GRANT cycle is legal and takes the WAIT exit path.
- Minimum per-transaction overhead is 3 cycles beyond mem_ctrl latency.
- All outputs are registered except the routed return signals (tx_done_src, rd_valid_src, rdata_src).

## Configuration

- Macro: MEM_SCHED_STARVE_EN.
- Defined:
  - Each source 1..N_SRC-1 has a saturating wait counter. It increments each cycle the source requests without being granted and clears when that source is granted.
  - A source whose counter is ≥ STARVE_LIMIT is starved. Starved sources beat source 0; ties among them are broken by round-robin order.
- Not defined:
  - No counters are built.
  - Source 0 always has strict priority.

## Test plan

- Single READ from source 2, addr 0x6000_0040, mem_ctrl tx_done after 5 cycles:
  - op = 01 and raw_address = 0x6000_0040 one cycle after the request.
  - tx_done_src = 4'b0100 and rdata routed to slot 2 only.
  - op = 00 for one cycle afterwards.
- Sources 0 and 3 request in the same cycle → source 0 is granted first, source 3 second; rr_ptr is unchanged after the source-0 grant.
- Sources 1, 2 and 3 request continuously → grant order 1, 2, 3, 1, 2, 3; wrap skips source 0.
- With MEM_SCHED_STARVE_EN, STARVE_LIMIT = 8, source 0 requesting continuously and source 1 waiting → source 1 is granted within 8 cycles plus one transaction. Without the macro, source 1 is never granted while source 0 requests.
- rst asserted in WAIT during a source 1 WRITE → op = 00, busy = 0 and grant_id = 0 next cycle; a later tx_done does not reach tx_done_src.
- Spurious tx_done in IDLE and op = 11 on source 2 → no grant and all outputs stay 0.

Source files
------------

// File: rtl/mem_port_scheduler.sv
// mem_port_scheduler
//   Shares one mem_ctrl transaction port among N_SRC requesters. Source 0
//   (instruction fetch) has fixed top priority. Sources 1..N_SRC-1 rotate
//   round-robin. Return signals are routed only to the granted source.
//
//   Optional feature macro: MEM_SCHED_STARVE_EN
//     Defined   : per-source wait counters. A source that waits >= STARVE_LIMIT
//                 cycles overrides source 0.
//     Undefined : no counters. Source 0 always has strict priority.
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   op_src/addr_src/wdata_src  per-source request (2 bit op, address, line)
//   rdata_src/tx_done_src/
//   rd_valid_src               per-source routed return (combinational)
//   op/raw_address/
//   common_data_bus_read_in    registered downstream request
//   common_data_bus_write_out  read data from mem_ctrl
//   tx_done, rd_valid          mem_ctrl completion and read-valid
//   grant_id                   current or last granted source
//   busy                       high in GRANT, WAIT and RELEASE
module mem_port_scheduler #(
  parameter int N_SRC        = 4,
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 512,
  parameter int STARVE_LIMIT = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_SRC*2-1:0]            op_src,
  input  logic [N_SRC*ADDR_WIDTH-1:0]   addr_src,
  input  logic [N_SRC*DATA_WIDTH-1:0]   wdata_src,
  output logic [N_SRC*DATA_WIDTH-1:0]   rdata_src,
  output logic [N_SRC-1:0]              tx_done_src,
  output logic [N_SRC-1:0]              rd_valid_src,
  output logic [1:0]                    op,
  output logic [ADDR_WIDTH-1:0]         raw_address,
  output logic [DATA_WIDTH-1:0]         common_data_bus_read_in,
  input  logic [DATA_WIDTH-1:0]         common_data_bus_write_out,
  input  logic                          tx_done,
  input  logic                          rd_valid,
  output logic [$clog2(N_SRC)-1:0]      grant_id,
  output logic                          busy
);

  localparam int ID_W = $clog2(N_SRC);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    WAIT    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t                  state_r, next_state_s;
  logic [ID_W-1:0]         rr_ptr_r;
  logic [ID_W-1:0]         grant_id_r;
  logic [1:0]              op_r;
  logic [ADDR_WIDTH-1:0]   addr_r;
  logic [DATA_WIDTH-1:0]   wdata_r;
  logic                    busy_r;

  logic [N_SRC-1:0]        req_s;
  logic [N_SRC-1:0]        starved_s;
  logic [ID_W:0]           rr_req_s;
  logic [ID_W:0]           rr_starve_s;
  logic                    win_valid_s;
  logic [ID_W-1:0]         win_id_s;
  logic                    route_en_s;

  // First set bit of mask among sources 1..N_SRC-1, searching from ptr with
  // wrap-around (source 0 never takes part). MSB of the result = found.
  function automatic logic [ID_W:0] rr_pick(input logic [N_SRC-1:0] mask,
                                            input logic [ID_W-1:0]  ptr);
    logic [ID_W:0] res;
    int            idx;
    res = '0;
    // Walk the order backwards so the earliest candidate is written last.
    for (int k = N_SRC - 2; k >= 0; k--) begin
      idx = ((int'(ptr) - 1 + k) % (N_SRC - 1)) + 1;
      res = mask[ID_W'(idx)] ? {1'b1, ID_W'(idx)} : res;
    end
    return res;
  endfunction

`ifdef MEM_SCHED_STARVE_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  logic [CNT_W-1:0] wait_cnt_r [1:N_SRC-1];
  logic [N_SRC-1:0] owner_s;

  // A source owns the port from the IDLE cycle it wins until RELEASE ends.
  always_comb begin
    owner_s = '0;
    for (int i = 1; i < N_SRC; i++) begin
      if (state_r == IDLE) begin
        owner_s[i] = win_valid_s && (win_id_s == ID_W'(i));
      end else begin
        owner_s[i] = (grant_id_r == ID_W'(i));
      end
    end
  end

  // Saturating wait counters for sources 1..N_SRC-1.
  always_ff @(posedge clk) begin
    for (int i = 1; i < N_SRC; i++) begin
      if (rst) begin
        wait_cnt_r[i] <= '0;
      end else if (owner_s[i]) begin
        wait_cnt_r[i] <= '0;
      end else if (req_s[i] && (wait_cnt_r[i] < CNT_W'(STARVE_LIMIT))) begin
        wait_cnt_r[i] <= wait_cnt_r[i] + CNT_W'(1);
      end else begin
        wait_cnt_r[i] <= wait_cnt_r[i];
      end
    end
  end
`endif

  // Request decode and winner selection (only consumed in IDLE).
  always_comb begin
    for (int i = 0; i < N_SRC; i++) begin
      req_s[i] = (op_src[2*i +: 2] == 2'b01) || (op_src[2*i +: 2] == 2'b10);
    end
    starved_s = '0;
`ifdef MEM_SCHED_STARVE_EN
    for (int i = 1; i < N_SRC; i++) begin
      starved_s[i] = req_s[i] && (wait_cnt_r[i] >= CNT_W'(STARVE_LIMIT));
    end
`endif
    rr_req_s    = rr_pick(req_s, rr_ptr_r);
    rr_starve_s = rr_pick(starved_s, rr_ptr_r);
    if (rr_starve_s[ID_W]) begin
      win_valid_s = 1'b1;
      win_id_s    = rr_starve_s[ID_W-1:0];
    end else if (req_s[0]) begin
      win_valid_s = 1'b1;
      win_id_s    = '0;
    end else begin
      win_valid_s = rr_req_s[ID_W];
      win_id_s    = rr_req_s[ID_W-1:0];
    end
  end

  // Next-state logic; tx_done in GRANT leaves the same way as from WAIT.
  always_comb begin
    next_state_s = IDLE;
    case (state_r)
      IDLE:    next_state_s = win_valid_s ? GRANT : IDLE;
      GRANT:   next_state_s = tx_done ? RELEASE : WAIT;
      WAIT:    next_state_s = tx_done ? RELEASE : WAIT;
      RELEASE: next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // State, latched downstream request, grant id and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      rr_ptr_r   <= ID_W'(1);
      grant_id_r <= '0;
      op_r       <= 2'b00;
      addr_r     <= '0;
      wdata_r    <= '0;
      busy_r     <= 1'b0;
    end else begin
      state_r <= next_state_s;
      busy_r  <= (next_state_s != IDLE);
      if ((state_r == IDLE) && win_valid_s) begin
        grant_id_r <= win_id_s;
        op_r       <= op_src[2*win_id_s +: 2];
        addr_r     <= addr_src[win_id_s*ADDR_WIDTH +: ADDR_WIDTH];
        wdata_r    <= wdata_src[win_id_s*DATA_WIDTH +: DATA_WIDTH];
        // Fetch wins leave the rotation untouched.
        if (win_id_s != '0) begin
          rr_ptr_r <= (win_id_s == ID_W'(N_SRC - 1)) ? ID_W'(1) : win_id_s + ID_W'(1);
        end else begin
          rr_ptr_r <= rr_ptr_r;
        end
      end else if (next_state_s == RELEASE) begin
        // One NOP cycle so mem_ctrl sees an op edge between transactions.
        op_r <= 2'b00;
      end else begin
        op_r <= op_r;
      end
    end
  end

  // Return routing: only the granted slot, only while GRANT or WAIT.
  always_comb begin
    route_en_s   = (state_r == GRANT) || (state_r == WAIT);
    tx_done_src  = '0;
    rd_valid_src = '0;
    rdata_src    = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (route_en_s && (grant_id_r == ID_W'(i))) begin
        tx_done_src[i]                     = tx_done;
        rd_valid_src[i]                    = rd_valid;
        rdata_src[i*DATA_WIDTH +: DATA_WIDTH] = common_data_bus_write_out;
      end else begin
        tx_done_src[i]                     = 1'b0;
        rd_valid_src[i]                    = 1'b0;
        rdata_src[i*DATA_WIDTH +: DATA_WIDTH] = '0;
      end
    end
  end

  assign op                      = op_r;
  assign raw_address             = addr_r;
  assign common_data_bus_read_in = wdata_r;
  assign grant_id                = grant_id_r;
  assign busy                    = busy_r;

endmodule

// File: tb/tb_mem_port_scheduler.sv
// tb_mem_port_scheduler
//   Directed-vector bench for mem_port_scheduler (N_SRC=4, STARVE_LIMIT=8).
//   Inputs change 1 time unit after a rising edge; outputs are checked there.
//   Covers single read routing, fetch priority vs. rotation, round-robin wrap,
//   fetch starvation (behaviour depends on MEM_SCHED_STARVE_EN), reset during
//   a transaction, and spurious tx_done / op 11 in IDLE.
module tb_mem_port_scheduler;

  localparam int NS = 4;
  localparam int AW = 32;
  localparam int DW = 512;

  logic               clk = 1'b0;
  logic               rst;
  logic [NS*2-1:0]    op_src;
  logic [NS*AW-1:0]   addr_src;
  logic [NS*DW-1:0]   wdata_src;
  logic [NS*DW-1:0]   rdata_src;
  logic [NS-1:0]      tx_done_src;
  logic [NS-1:0]      rd_valid_src;
  logic [1:0]         op;
  logic [AW-1:0]      raw_address;
  logic [DW-1:0]      common_data_bus_read_in;
  logic [DW-1:0]      common_data_bus_write_out;
  logic               tx_done;
  logic               rd_valid;
  logic [1:0]         grant_id;
  logic               busy;

  int n_vec  = 0;
  int n_miss = 0;

  mem_port_scheduler #(
    .N_SRC(NS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(8)
  ) dut (
    .clk(clk), .rst(rst),
    .op_src(op_src), .addr_src(addr_src), .wdata_src(wdata_src),
    .rdata_src(rdata_src), .tx_done_src(tx_done_src), .rd_valid_src(rd_valid_src),
    .op(op), .raw_address(raw_address),
    .common_data_bus_read_in(common_data_bus_read_in),
    .common_data_bus_write_out(common_data_bus_write_out),
    .tx_done(tx_done), .rd_valid(rd_valid),
    .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] wdata_of(input int i);
    logic [31:0] w;
    w = 32'hA500_0000 | 32'(i);
    return {16{w}};
  endfunction

  function automatic logic [DW-1:0] line_of(input int i);
    logic [63:0] w;
    w = 64'hC0DE_0000_0000_0000 | 64'(i);
    return {8{w}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int i, input logic [1:0] o, input logic [AW-1:0] a);
    op_src[2*i +: 2]    = o;
    addr_src[i*AW +: AW] = a;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    op_src = '0;
    tx_done = 1'b0;
    rd_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Check every rdata slot: only slot g carries exp_line.
  task automatic check_rdata(input int g, input logic [DW-1:0] exp_line);
    for (int i = 0; i < NS; i++) begin
      check_vec($sformatf("rdata_slot%0d", i), rdata_src[i*DW +: DW],
                (i == g) ? exp_line : '0);
    end
  endtask

  // One full transaction starting from IDLE (called #1 after an edge).
  // exp_g < 0 accepts any winner; the winner is returned in got_g.
  task automatic serve(input int exp_g, input logic [1:0] exp_op, input logic [AW-1:0] exp_addr,
                       input int waits, input logic drop, output int got_g);
    logic [NS-1:0] oh;
    tick();
    got_g = int'(grant_id);
    check_vec("grant_busy", {511'd0, busy}, 512'd1);
    if (exp_g >= 0) begin
      check_vec("grant_id", {510'd0, grant_id}, 512'(exp_g));
      check_vec("grant_op", {510'd0, op}, {510'd0, exp_op});
      check_vec("grant_addr", {480'd0, raw_address}, {480'd0, exp_addr});
      if (exp_op == 2'b10) begin
        check_vec("grant_wdata", common_data_bus_read_in, wdata_of(exp_g));
      end
    end
    for (int w = 0; w < waits; w++) begin
      tick();
      check_vec("wait_op_hold", {510'd0, op}, {510'd0, exp_op});
      check_vec("wait_no_done", {508'd0, tx_done_src}, 512'd0);
    end
    oh = 4'b0001 << got_g;
    common_data_bus_write_out = line_of(got_g);
    tx_done  = 1'b1;
    rd_valid = (exp_op != 2'b10);
    #1;
    check_vec("tx_done_src", {508'd0, tx_done_src}, {508'd0, oh});
    check_vec("rd_valid_src", {508'd0, rd_valid_src}, rd_valid ? {508'd0, oh} : 512'd0);
    check_rdata(got_g, line_of(got_g));
    tick();
    tx_done  = 1'b0;
    rd_valid = 1'b0;
    if (drop) op_src[2*got_g +: 2] = 2'b00;
    check_vec("release_op", {510'd0, op}, 512'd0);
    check_vec("release_busy", {511'd0, busy}, 512'd1);
    check_vec("release_no_done", {508'd0, tx_done_src}, 512'd0);
    tick();
    check_vec("idle_busy", {511'd0, busy}, 512'd0);
  endtask

  initial begin
    int g;
    int seen;
    rst = 1'b1;
    op_src = '0;
    addr_src = '0;
    wdata_src = '0;
    tx_done = 1'b0;
    rd_valid = 1'b0;
    common_data_bus_write_out = '0;
    for (int i = 0; i < NS; i++) wdata_src[i*DW +: DW] = wdata_of(i);

    // Reset state
    do_reset();
    check_vec("rst_op", {510'd0, op}, 512'd0);
    check_vec("rst_busy", {511'd0, busy}, 512'd0);
    check_vec("rst_grant", {510'd0, grant_id}, 512'd0);
    check_vec("rst_addr", {480'd0, raw_address}, 512'd0);

    // Single READ from source 2, tx_done 5 cycles after the request edge
    set_src(2, 2'b01, 32'h6000_0040);
    serve(2, 2'b01, 32'h6000_0040, 4, 1'b1, g);

    // Sources 0 and 3 together: 0 first; rr_ptr stays 3 so 3 beats 1 next
    set_src(0, 2'b01, 32'h0000_1000);
    set_src(3, 2'b10, 32'h3000_0300);
    serve(0, 2'b01, 32'h0000_1000, 1, 1'b1, g);
    set_src(1, 2'b01, 32'h1000_0100);
    serve(3, 2'b10, 32'h3000_0300, 0, 1'b1, g);
    serve(1, 2'b01, 32'h1000_0100, 2, 1'b1, g);

    // Sources 1,2,3 continuously: 1,2,3,1,2,3
    do_reset();
    set_src(1, 2'b01, 32'h1000_0000);
    set_src(2, 2'b10, 32'h2000_0000);
    set_src(3, 2'b01, 32'h3000_0000);
    for (int t = 0; t < 6; t++) begin
      serve((t % 3) + 1, (t % 3 == 1) ? 2'b10 : 2'b01,
            32'h1000_0000 * ((t % 3) + 1), 0, 1'b0, g);
    end

    // Fetch requesting continuously with source 1 waiting
    do_reset();
    set_src(0, 2'b01, 32'h0000_2000);
    set_src(1, 2'b01, 32'h1000_0200);
`ifdef MEM_SCHED_STARVE_EN
    seen = 0;
    for (int t = 0; t < 4; t++) begin
      if (seen == 0) begin
        serve(-1, 2'b01, 32'h0, 0, 1'b0, g);
        if (g == 1) seen = 1;
      end
    end
    check_vec("starve_src1_granted", 512'(seen), 512'd1);
`else
    for (int t = 0; t < 4; t++) serve(0, 2'b01, 32'h0000_2000, 0, 1'b0, g);
    set_src(0, 2'b00, 32'h0);
    serve(1, 2'b01, 32'h1000_0200, 0, 1'b1, g);
`endif

    // Reset in WAIT during a source 1 WRITE
    do_reset();
    set_src(1, 2'b10, 32'h1000_0100);
    tick();
    check_vec("rw_grant_op", {510'd0, op}, 512'd2);
    check_vec("rw_grant_id", {510'd0, grant_id}, 512'd1);
    tick();
    rst = 1'b1;
    op_src = '0;
    tick();
    rst = 1'b0;
    check_vec("rw_op", {510'd0, op}, 512'd0);
    check_vec("rw_busy", {511'd0, busy}, 512'd0);
    check_vec("rw_grant", {510'd0, grant_id}, 512'd0);
    tx_done = 1'b1;
    #1;
    check_vec("rw_late_done", {508'd0, tx_done_src}, 512'd0);
    tick();
    tx_done = 1'b0;
    check_vec("rw_stay_idle", {511'd0, busy}, 512'd0);

    // Spurious tx_done in IDLE and op 11 on source 2
    set_src(2, 2'b11, 32'h2222_0000);
    tx_done = 1'b1;
    rd_valid = 1'b1;
    common_data_bus_write_out = line_of(7);
    #1;
    check_vec("sp_tx_done_src", {508'd0, tx_done_src}, 512'd0);
    check_vec("sp_rd_valid_src", {508'd0, rd_valid_src}, 512'd0);
    check_rdata(-1, '0);
    tick();
    tick();
    check_vec("sp_busy", {511'd0, busy}, 512'd0);
    check_vec("sp_op", {510'd0, op}, 512'd0);
    check_vec("sp_grant", {510'd0, grant_id}, 512'd0);
    check_vec("sp_addr", {480'd0, raw_address}, 512'd0);
    check_vec("sp_wdata", common_data_bus_read_in, '0);
    tx_done = 1'b0;
    rd_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
